// File: rtl/fp_trunc_sched.sv
// rtl/fp_trunc_sched.sv - round-robin scheduler sharing one FP32 truncate unit among NREQ requesters
module fp_trunc_sched #(
    parameter  int NREQ = 4,
    localparam int TW   = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*32-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      resp_valid,
    output logic [NREQ*32-1:0]   resp_data,
    output logic [NREQ-1:0]      resp_ovf,
    input  logic [NREQ-1:0]      resp_ready,
    output logic                 unit_ce,
    output logic [31:0]          unit_i,
    input  logic [31:0]          unit_o,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_PENDING = 2'd1,
        S_FULL    = 2'd2
    } slot_t;

    slot_t           state_q [NREQ];
    slot_t           state_d [NREQ];
    logic [31:0]     data_q  [NREQ];
    logic [NREQ-1:0] ovf_q;
    logic [TW-1:0]   ptr_q;
    logic [TW-1:0]   ptr_d;
    logic [TW-1:0]   gnt_idx;
    logic            any_gnt;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] gnt_oh;
    logic            ovf_now;

    // A popping slot is still FULL this cycle, so it cannot be re-granted until the next one.
    always_comb begin
        elig = '0;
        for (int k = 0; k < NREQ; k++) begin
            elig[k] = rst_n && req_valid[k] && (state_q[k] == S_EMPTY);
        end
    end

    always_comb begin
        logic [TW:0] idx;
        any_gnt = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, ptr_q} + (TW+1)'(i);
            if (idx >= (TW+1)'(NREQ)) begin
                idx = idx - (TW+1)'(NREQ);
            end
            if (!any_gnt && elig[idx[TW-1:0]]) begin
                any_gnt = 1'b1;
                gnt_idx = idx[TW-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (any_gnt) begin
            ptr_d = (gnt_idx == TW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign gnt_oh    = any_gnt ? (NREQ'(1) << gnt_idx) : '0;
    assign req_ready = gnt_oh;
    assign unit_ce   = any_gnt;
    assign unit_i    = any_gnt ? req_data[32*gnt_idx +: 32] : 32'h0;

    // Exponent >= 158 means |x| >= 2^31, Inf or NaN; -2^31 itself still fits int32.
    assign ovf_now = (unit_o[30:23] >= 8'd158) && (unit_o != 32'hCF00_0000);

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            state_d[k] = state_q[k];
            case (state_q[k])
                S_EMPTY:   if (gnt_oh[k]) state_d[k] = S_PENDING;
                S_PENDING: state_d[k] = S_FULL;
                S_FULL:    if (resp_ready[k]) state_d[k] = S_EMPTY;
                default:   state_d[k] = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            ovf_q <= '0;
            for (int k = 0; k < NREQ; k++) begin
                state_q[k] <= S_EMPTY;
                data_q[k]  <= 32'h0;
            end
        end else begin
            ptr_q <= ptr_d;
            for (int k = 0; k < NREQ; k++) begin
                state_q[k] <= state_d[k];
                if (state_q[k] == S_PENDING) begin
                    data_q[k] <= unit_o;
                    ovf_q[k]  <= ovf_now;
                end
            end
        end
    end

    always_comb begin
        resp_valid = '0;
        resp_data  = '0;
        busy       = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            resp_valid[k]        = (state_q[k] == S_FULL);
            resp_data[32*k +: 32] = data_q[k];
            busy                 = busy | (state_q[k] != S_EMPTY);
        end
    end

    assign resp_ovf = ovf_q & resp_valid;

endmodule

// File: tb/tb_fp_trunc_sched.sv
// tb/tb_fp_trunc_sched.sv - self-checking bench for fp_trunc_sched with a truncate-unit model and scoreboard
module tb_fp_trunc_sched;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*32-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   resp_valid;
    logic [N*32-1:0] resp_data;
    logic [N-1:0]   resp_ovf;
    logic [N-1:0]   resp_ready = '0;
    logic           unit_ce;
    logic [31:0]    unit_i;
    logic [31:0]    unit_o = 32'h0;
    logic           busy;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    logic [32:0]  sb [N][$];
    logic [N-1:0] prev_rv = '0;
    logic [N-1:0] prev_pop = '0;
    logic [31:0]  prev_d [N];
    int           gcyc [N];

    fp_trunc_sched #(.NREQ(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_ovf(resp_ovf),
        .resp_ready(resp_ready),
        .unit_ce(unit_ce), .unit_i(unit_i), .unit_o(unit_o), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Truncate toward zero; magnitudes below 1 give +0.
    function automatic logic [31:0] trunc32(input logic [31:0] x);
        logic [7:0]  e;
        logic [31:0] m;
        e = x[30:23];
        if (e == 8'hFF) return x;
        if (e < 8'd127) return 32'h0;
        if (e >= 8'd150) return x;
        m = 32'hFFFF_FFFF << (150 - int'(e));
        return x & m;
    endfunction

    function automatic logic exp_ovf(input logic [31:0] x);
        logic [31:0] r;
        r = trunc32(x);
        return (r[30:0] >= 31'h4F00_0000) && (r != 32'hCF00_0000);
    endfunction

    always @(posedge clk) if (unit_ce) unit_o <= trunc32(unit_i);

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) sb[k].delete();
            prev_rv = '0;
            prev_pop = '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (req_valid[k] && req_ready[k]) begin
                    sb[k].push_back({exp_ovf(req_data[32*k +: 32]), trunc32(req_data[32*k +: 32])});
                    gcyc[k] = cyc;
                end
                if (resp_valid[k] && !prev_rv[k]) begin
                    total_cnt++;
                    if (cyc !== gcyc[k] + 2)
                        $display("FAIL latency[%0d]: resp at cycle %0d, required %0d", k, cyc, gcyc[k] + 2);
                    else pass_cnt++;
                end
                if (resp_valid[k] && prev_rv[k] && !prev_pop[k]) begin
                    total_cnt++;
                    if (resp_data[32*k +: 32] !== prev_d[k])
                        $display("FAIL stable[%0d]: got %h, required %h", k, resp_data[32*k +: 32], prev_d[k]);
                    else pass_cnt++;
                end
                if (resp_valid[k] && resp_ready[k]) begin
                    total_cnt++;
                    if (sb[k].size() == 0) begin
                        $display("FAIL unexpected_resp[%0d]: got %h, required no response", k, resp_data[32*k +: 32]);
                    end else begin
                        logic [32:0] e;
                        e = sb[k].pop_front();
                        if ({resp_ovf[k], resp_data[32*k +: 32]} !== e)
                            $display("FAIL sb_resp[%0d]: got ovf=%b data=%h, required ovf=%b data=%h",
                                     k, resp_ovf[k], resp_data[32*k +: 32], e[32], e[31:0]);
                        else pass_cnt++;
                    end
                end
                prev_rv[k]  = resp_valid[k];
                prev_pop[k] = resp_valid[k] & resp_ready[k];
                prev_d[k]   = resp_data[32*k +: 32];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        resp_ready = '1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic issue(input int k, input logic [31:0] d);
        int n;
        n = 0;
        req_data[32*k +: 32] = d;
        req_valid[k] = 1'b1;
        @(negedge clk);
        while (!req_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (!req_ready[k]) $display("FAIL grant_timeout[%0d]: req_ready=%b, required grant", k, req_ready);
        else pass_cnt++;
        tick();
        req_valid[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '1;
        resp_ready = '1;
        req_data = {32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
        @(negedge clk);
        total_cnt++;
        if (req_ready !== '0) $display("FAIL rst_req_ready: got %b, required 0", req_ready); else pass_cnt++;
        total_cnt++;
        if (resp_valid !== '0 || resp_ovf !== '0) $display("FAIL rst_resp: got v=%b o=%b, required 0", resp_valid, resp_ovf); else pass_cnt++;
        total_cnt++;
        if (resp_data !== '0) $display("FAIL rst_resp_data: got %h, required 0", resp_data); else pass_cnt++;
        total_cnt++;
        if (unit_ce !== 1'b0 || unit_i !== 32'h0 || busy !== 1'b0)
            $display("FAIL rst_unit: got ce=%b i=%h busy=%b, required 0", unit_ce, unit_i, busy);
        else pass_cnt++;
        req_valid = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        req_data[31:0] = 32'h4070_0000;
        req_valid[0] = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (req_ready !== 4'b0001 || unit_ce !== 1'b1 || unit_i !== 32'h4070_0000 || busy !== 1'b0)
            $display("FAIL basic_c0: got rdy=%b ce=%b i=%h busy=%b, required 0001 1 40700000 0", req_ready, unit_ce, unit_i, busy);
        else pass_cnt++;
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b1 || resp_valid !== 4'b0000)
            $display("FAIL basic_c1: got busy=%b rv=%b, required 1 0000", busy, resp_valid);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (resp_valid !== 4'b0001 || resp_data[31:0] !== 32'h4040_0000 || resp_ovf[0] !== 1'b0 || busy !== 1'b1)
            $display("FAIL basic_c2: got rv=%b d=%h o=%b busy=%b, required 0001 40400000 0 1",
                     resp_valid, resp_data[31:0], resp_ovf[0], busy);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0 || resp_valid !== 4'b0000)
            $display("FAIL basic_c3: got busy=%b rv=%b, required 0 0000", busy, resp_valid);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_special();
        int          ks [7]  = '{2, 3, 1, 0, 2, 3, 1};
        logic [31:0] ds [7]  = '{32'hBF00_0000, 32'h4F00_0000, 32'hCF00_0000, 32'h7F80_0000,
                                 32'h4EFF_FFFF, 32'hC0F0_0000, 32'h7FC0_0000};
        logic [31:0] es [7]  = '{32'h0000_0000, 32'h4F00_0000, 32'hCF00_0000, 32'h7F80_0000,
                                 32'h4EFF_FFFF, 32'hC0E0_0000, 32'h7FC0_0000};
        logic        os [7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            issue(ks[i], ds[i]);
            @(posedge clk);
            @(negedge clk);
            total_cnt++;
            if (resp_valid[ks[i]] !== 1'b1 || resp_data[32*ks[i] +: 32] !== es[i] || resp_ovf[ks[i]] !== os[i])
                $display("FAIL special[%0d]: got v=%b d=%h o=%b, required 1 %h %b", i,
                         resp_valid[ks[i]], resp_data[32*ks[i] +: 32], resp_ovf[ks[i]], es[i], os[i]);
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_round_robin();
        int e;
        do_reset();
        for (int k = 0; k < N; k++) req_data[32*k +: 32] = $urandom;
        req_valid = '1;
        e = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            total_cnt++;
            if (req_ready !== 4'(1 << e) || unit_ce !== 1'b1)
                $display("FAIL rr[%0d]: got rdy=%b ce=%b, required %b 1", i, req_ready, unit_ce, 4'(1 << e));
            else pass_cnt++;
            tick();
            req_data[32*e +: 32] = $urandom;
            e = (e + 1) % N;
        end
        req_valid = '0;
        repeat (4) tick();
    endtask

    task automatic test_fairness();
        do_reset();
        issue(1, 32'h3F80_0000);
        repeat (3) tick();
        req_data[31:0]  = 32'h4120_0000;
        req_data[127:96] = 32'hC120_0000;
        req_valid[0] = 1'b1;
        req_valid[3] = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (req_ready !== 4'b1000) $display("FAIL fair_first: got %b, required 1000", req_ready); else pass_cnt++;
        tick();
        req_valid[3] = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (req_ready !== 4'b0001) $display("FAIL fair_second: got %b, required 0001", req_ready); else pass_cnt++;
        tick();
        req_valid[0] = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_backpressure();
        int   g0;
        logic gr;
        g0 = 0;
        resp_ready = '1;
        resp_ready[1] = 1'b0;
        issue(1, 32'h4120_0000);
        tick();
        req_data[63:32] = 32'h40A0_0000;
        req_valid[1] = 1'b1;
        req_data[31:0] = $urandom;
        req_valid[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total_cnt++;
            if (req_ready[1] !== 1'b0 || resp_valid[1] !== 1'b1 || resp_data[63:32] !== 32'h4120_0000)
                $display("FAIL bp_hold[%0d]: got rdy1=%b rv1=%b d1=%h, required 0 1 41200000",
                         i, req_ready[1], resp_valid[1], resp_data[63:32]);
            else pass_cnt++;
            gr = req_ready[0];
            if (gr) g0++;
            tick();
            if (gr) req_data[31:0] = $urandom;
        end
        total_cnt++;
        if (g0 < 2) $display("FAIL bp_others: got %0d grants to req0, required >= 2", g0); else pass_cnt++;
        req_valid[0] = 1'b0;
        resp_ready[1] = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (resp_valid[1] !== 1'b1 || req_ready[1] !== 1'b0)
            $display("FAIL bp_pop: got rv1=%b rdy1=%b, required 1 0", resp_valid[1], req_ready[1]);
        else pass_cnt++;
        tick();
        @(negedge clk);
        total_cnt++;
        if (req_ready[1] !== 1'b1) $display("FAIL bp_regrant: got %b, required 1", req_ready[1]); else pass_cnt++;
        tick();
        req_valid[1] = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset_midop();
        do_reset();
        issue(2, 32'h4000_0000);
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (resp_valid !== '0 || busy !== 1'b0)
            $display("FAIL midrst: got rv=%b busy=%b, required 0000 0", resp_valid, busy);
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        req_data[31:0]   = 32'h4000_0000;
        req_data[127:96] = 32'h4040_0000;
        req_valid[0] = 1'b1;
        req_valid[3] = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (req_ready !== 4'b0001) $display("FAIL midrst_ptr: got %b, required 0001", req_ready); else pass_cnt++;
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (req_ready !== 4'b1000) $display("FAIL midrst_next: got %b, required 1000", req_ready); else pass_cnt++;
        tick();
        req_valid[3] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total_cnt++;
            if (resp_valid[2] !== 1'b0) $display("FAIL midrst_stale[%0d]: got rv2=%b, required 0", i, resp_valid[2]);
            else pass_cnt++;
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_special();
        test_round_robin();
        test_fairness();
        test_backpressure();
        test_reset_midop();
        repeat (4) tick();
        for (int k = 0; k < N; k++) begin
            total_cnt++;
            if (sb[k].size() != 0) $display("FAIL sb_drain[%0d]: got %0d outstanding, required 0", k, sb[k].size());
            else pass_cnt++;
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
